// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobed 4x4 matrix keypad reader with whole-scan
// debounce, multi-key rejection, a one-cycle press strobe and a held level.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } state_t;

    logic [3:0]    row_meta;
    logic [3:0]    row_s;
    logic [TW-1:0] tick;
    logic [1:0]    col_idx;
    logic [1:0]    idx_next;
    logic [1:0]    pressed_count;
    logic [3:0]    cand_code;

    logic          terminal;
    logic          scan_done;
    logic [3:0]    row_low;
    logic [2:0]    popc;
    logic [2:0]    sum;
    logic [1:0]    count_n;
    logic [1:0]    low_row;
    logic [3:0]    cand_n;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [3:0]    pend;
    logic [3:0]    pend_n;
    logic [3:0]    code_n;
    logic          valid_n;

    assign terminal  = (tick == TICK_LAST);
    assign scan_done = terminal && (col_idx == 2'd3);
    assign idx_next  = col_idx + 2'd1;
    assign key_held  = (state == HELD) || (state == REL_DB);

    // Two-flop synchronizer for the asynchronous row lines (idle high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'b1111;
            row_s    <= 4'b1111;
        end else begin
            row_meta <= row;
            row_s    <= row_meta;
        end
    end

    // Fold the current column's rows into the running scan result.
    always_comb begin
        row_low = ~row_s;
        popc    = {2'b00, row_low[0]} + {2'b00, row_low[1]}
                + {2'b00, row_low[2]} + {2'b00, row_low[3]};
        sum     = {1'b0, pressed_count} + popc;
        count_n = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        if (row_low[0])      low_row = 2'd0;
        else if (row_low[1]) low_row = 2'd1;
        else if (row_low[2]) low_row = 2'd2;
        else                 low_row = 2'd3;
        cand_n = cand_code;
        // Columns are visited in ascending order, so the first hit wins.
        if ((pressed_count == 2'd0) && (|row_low)) begin
            cand_n = {low_row, col_idx};
        end
    end

    // Tick counter, column strobe and per-scan accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick          <= '0;
            col_idx       <= '0;
            col           <= 4'b1110;
            pressed_count <= '0;
            cand_code     <= '0;
        end else begin
            if (terminal) begin
                tick    <= '0;
                col_idx <= idx_next;
                col     <= ~(4'b0001 << idx_next);
                if (col_idx == 2'd3) begin
                    pressed_count <= '0;
                    cand_code     <= '0;
                end else begin
                    pressed_count <= count_n;
                    cand_code     <= cand_n;
                end
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

    // Debounce FSM state, counters and registered key outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pend      <= pend_n;
            key_code  <= code_n;
            key_valid <= valid_n;
        end
    end

    // Next-state logic, evaluated only on the scan-complete cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        code_n  = key_code;
        valid_n = 1'b0;
        if (scan_done) begin
            unique case (state)
                IDLE: begin
                    if (count_n == 2'd1) begin
                        pend_n  = cand_n;
                        cnt_n   = CW'(1);
                        state_n = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (count_n == 2'd1) begin
                        if (cand_n == pend) begin
                            if (cnt == CNT_LAST) begin
                                code_n  = cand_n;
                                valid_n = 1'b1;
                                state_n = HELD;
                            end else begin
                                cnt_n = cnt + CW'(1);
                            end
                        end else begin
                            pend_n = cand_n;
                            cnt_n  = CW'(1);
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (count_n == 2'd0) begin
                        cnt_n   = CW'(1);
                        state_n = REL_DB;
                    end
                end
                REL_DB: begin
                    if (count_n == 2'd0) begin
                        if (cnt == CNT_LAST) begin
                            state_n = IDLE;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else begin
                        state_n = HELD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
